wb_burst_ram: RTL and testbench
===============================

Name: wb_burst_ram

Overview:
- Wishbone B3 slave: 32-bit single-port on-chip RAM. It is the responder end of the bus that the wb_mux/wb_arbiter interconnect drives toward the memory slave.
- Supports classic cycles and registered-feedback bursts (cti/bte) with single-cycle-per-beat throughput after a 1-cycle initial latency.
- Byte-granular writes via sel. Memory contents are not reset.

Parameters:
- DEPTH, 1024, memory size in 32-bit words; must be a power of 2, minimum 16.
- AW, $clog2(DEPTH), word-address width (derived; do not override).

Ports:
- wb_clk_i  in  1  bus clock; all state updates on the rising edge.
- wb_rst_ni  in  1  asynchronous active-low reset.
- wb_adr_i  in  32  byte address; bits [AW+1:2] select the word; other bits are ignored.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte enables; bit n enables byte lane [8n+7:8n].
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe.
- wb_cti_i  in  3  cycle type: 000 classic, 001 constant-address, 010 incrementing, 111 end-of-burst; other values are treated as 000.
- wb_bte_i  in  2  burst type: 00 linear, 01 4-beat wrap, 10 8-beat wrap, 11 16-beat wrap.
- wb_dat_o  out  32  read data, registered.
- wb_ack_o  out  1  beat acknowledge, registered.
- wb_err_o  out  1  tied 0.
- wb_rty_o  out  1  tied 0.

Behaviour:
- Reset (async assert, sync-safe deassert): wb_ack_o=0, wb_dat_o=0, internal beat address=0. Memory is untouched. Reset asserted mid-burst aborts the burst; the next access after reset is a new access.
- Definitions:
  - req = cyc & stb.
  - burst = cti in {001,010}.
  - last = (cti==111) or not burst.
- Ack register:
  - if ack_o=0: ack_o <= req.
  - if ack_o=1: ack_o <= req & burst & cti!=111.
  - Consequences: classic and single accesses are acked for exactly 1 cycle, then ack drops for at least 1 cycle. A burst acks every cycle until the cti=111 beat has been acked.
- New access (edge where ack_o=0 and req): the beat address is loaded from wb_adr_i[AW+1:2], and wb_dat_o <= mem[adr_i word].
- Burst continuation (edge where ack_o=1 and the next ack_o=1): the beat address advances to next(beat address), and wb_dat_o <= mem[next].
- next(a):
  - cti=001: a.
  - bte=00: a+1, modulo DEPTH.
  - bte=01/10/11: low 2/3/4 bits incremented modulo 4/8/16; upper bits held.
- Write: at each edge where req & we & ack_o, each byte lane with sel=1 of mem[beat address] is written with wb_dat_i. Write data is sampled in the acked cycle.
- Read data: wb_dat_o is valid in every cycle where ack_o=1. A write beat's wb_dat_o content is unspecified.
- Master wait state (stb low mid-burst while cyc high): ack drops the next cycle. Raising stb again starts a new access from wb_adr_i, with 1-cycle latency.
- cyc dropped mid-burst: ack drops the next cycle. Writes complete only for beats where ack_o was already 1.
- we changing within a burst is honoured per beat.
- Address wrap at DEPTH in linear mode: silently wraps to word 0.
- Reserved cti values behave as 000.

Test Plan:
1. Classic write then read, DEPTH=1024: write 0xDEADBEEF to 0x10 with sel=F, then read 0x10.
   - Required: each ack is high for 1 cycle, arriving 1 cycle after stb. Read returns 0xDEADBEEF.
2. Byte lanes:
   - Stimulus: preload 0x11223344 at 0x20; write 0xAABBCCDD with sel=0101; read back.
   - Required: 0x11BB33DD.
3. Incrementing linear read burst:
   - Stimulus: words 0..7 hold i*0x01010101; cti=010, bte=00, adr=0x8, 4 beats with the last beat cti=111.
   - Required: ack high for 4 consecutive cycles, data 0x02020202..0x05050505, ack then low.
4. 4-beat wrap read burst at adr=0x18 (word 6):
   - Required: data from words 6,7,4,5; 4 contiguous acks.
   - Repeat as a write burst; verify the same words by classic reads.
5. Wait state and cyc abort mid-burst:
   - Drop stb after 2 acks of an 8-beat incrementing burst from word 0, then re-raise stb with adr=0x8.
     - Required: ack gap of ≥1 cycle, then data from word 2.
   - Separately, drop cyc after 2 write acks.
     - Required: only words 0 and 1 are modified.
6. Async reset mid-burst: assert wb_rst_ni=0 between edges during a burst.
   - Required: ack_o and dat_o go to 0 immediately; memory keeps its prior contents.
   - After release, a classic read of word 3 returns the earlier value.

Source files
------------

// File: rtl/wb_burst_ram.sv
// Wishbone B3 slave: single-port 32-bit RAM with classic and registered-feedback
// burst support (cti/bte), one beat per cycle after a 1-cycle initial latency.
module wb_burst_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o
);

    localparam logic [2:0] CTI_CONST = 3'b001;
    localparam logic [2:0] CTI_INCR  = 3'b010;

    logic [31:0]   mem [DEPTH];

    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;
    logic [AW-1:0] adr_q, adr_d;

    logic          req, burst, new_acc, cont, wr_en, fwd_hit;
    logic [AW-1:0] nxt_adr, rd_adr;
    logic [31:0]   rd_word, fwd_word;
    logic [3:0]    lane_we;

    always_comb begin
        req     = wb_cyc_i & wb_stb_i;
        burst   = (wb_cti_i == CTI_CONST) || (wb_cti_i == CTI_INCR);
        ack_d   = ack_q ? (req & burst) : req;
        new_acc = ~ack_q & req;
        cont    = ack_q & ack_d;
        wr_en   = req & wb_we_i & ack_q;

        // Wrapping bursts only advance the low bits; upper bits stay pinned.
        nxt_adr = adr_q;
        if (wb_cti_i != CTI_CONST) begin
            case (wb_bte_i)
                2'b00:   nxt_adr      = adr_q + AW'(1);
                2'b01:   nxt_adr[1:0] = adr_q[1:0] + 2'd1;
                2'b10:   nxt_adr[2:0] = adr_q[2:0] + 3'd1;
                default: nxt_adr[3:0] = adr_q[3:0] + 4'd1;
            endcase
        end

        rd_adr  = new_acc ? wb_adr_i[AW+1:2] : nxt_adr;
        adr_d   = (new_acc | cont) ? rd_adr : adr_q;
        rd_word = mem[rd_adr];
        fwd_hit = wr_en && (rd_adr == adr_q);
        dat_d   = (new_acc | cont) ? fwd_word : dat_q;
    end

    // A constant-address burst may read the word being written on the same edge.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_we[gi] = wr_en & wb_sel_i[gi];
        assign fwd_word[8*gi +: 8] = (fwd_hit && wb_sel_i[gi]) ? wb_dat_i[8*gi +: 8]
                                                               : rd_word[8*gi +: 8];
    end

    always_ff @(posedge wb_clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (lane_we[b]) begin
                mem[adr_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= '0;
            adr_q <= '0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
            adr_q <= adr_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;

    logic unused_adr;
    assign unused_adr = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};

endmodule

// File: tb/tb_wb_burst_ram.sv
// Directed and randomized bench for wb_burst_ram, checked against a word-array
// reference model that computes burst addresses arithmetically.
module tb_wb_burst_ram;

    localparam int DEPTH = 1024;

    logic        clk, rst_n;
    logic [31:0] adr, wdat, rdat;
    logic [3:0]  sel;
    logic        we, cyc, stb, ack, err, rty;
    logic [2:0]  cti;
    logic [1:0]  bte;

    logic [31:0] ref_mem [DEPTH];
    int          checks = 0;
    int          errors = 0;
    logic        obs_ack;
    logic [31:0] obs_dat;

    wb_burst_ram #(.DEPTH(DEPTH)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wb_adr_i (adr),
        .wb_dat_i (wdat),
        .wb_sel_i (sel),
        .wb_we_i  (we),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_cti_i (cti),
        .wb_bte_i (bte),
        .wb_dat_o (rdat),
        .wb_ack_o (ack),
        .wb_err_o (err),
        .wb_rty_o (rty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive just after the rising edge, sample at the falling edge.
    task automatic step(input logic c, input logic s, input logic w, input logic [2:0] t,
                        input logic [1:0] b, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] sl);
        @(posedge clk);
        #1;
        cyc = c; stb = s; we = w; cti = t; bte = b; adr = a; wdat = d; sel = sl;
        @(negedge clk);
        obs_ack = ack;
        obs_dat = rdat;
        $display("cyc=%0b stb=%0b we=%0b cti=%03b bte=%0d adr=%08h dat_i=%08h sel=%h -> ack=%0b dat_o=%08h",
                 c, s, w, t, b, a, d, sl, obs_ack, obs_dat);
    endtask

    task automatic idle();
        step(0, 0, 0, 3'b000, 2'b00, 32'h0, 32'h0, 4'h0);
    endtask

    function automatic void model_write(int a, logic [31:0] d, logic [3:0] sl);
        for (int b = 0; b < 4; b++)
            if (sl[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    endfunction

    function automatic int exp_addr(int start, int i, logic [2:0] kind, logic [1:0] bt);
        int len;
        if (kind == 3'b001) return start;
        if (bt == 2'b00) return (start + i) % DEPTH;
        len = 2 << bt;
        return (start / len) * len + (start % len + i) % len;
    endfunction

    // Classic single access with the given cti (000 or a reserved code).
    task automatic classic(input logic w, input int word, input logic [31:0] d,
                           input logic [3:0] sl, input logic [2:0] t, input string tag);
        step(1, 1, w, t, 2'b00, word * 4, d, sl);
        chk($sformatf("%s_lat", tag), {31'b0, obs_ack}, 32'd0);
        step(1, 1, w, t, 2'b00, word * 4, d, sl);
        chk($sformatf("%s_ack", tag), {31'b0, obs_ack}, 32'd1);
        if (w) model_write(word, d, sl);
        else   chk($sformatf("%s_dat", tag), obs_dat, ref_mem[word]);
        idle();
        chk($sformatf("%s_drop", tag), {31'b0, obs_ack}, 32'd0);
    endtask

    task automatic do_burst(input int start, input int n, input logic [2:0] kind,
                            input logic [1:0] bt, input logic [15:0] wemask,
                            input bit rand_sel, input string tag);
        logic [31:0] wd [16];
        logic [3:0]  sl [16];
        logic [2:0]  t;
        int          a;
        for (int i = 0; i < n; i++) begin
            wd[i] = $urandom;
            sl[i] = rand_sel ? 4'($urandom) : 4'hF;
        end
        t = (n == 1) ? 3'b000 : kind;
        step(1, 1, wemask[0], t, bt, start * 4, wd[0], sl[0]);
        chk($sformatf("%s_lat", tag), {31'b0, obs_ack}, 32'd0);
        for (int i = 0; i < n; i++) begin
            a = exp_addr(start, i, kind, bt);
            t = (n == 1) ? 3'b000 : ((i == n - 1) ? 3'b111 : kind);
            step(1, 1, wemask[i], t, bt, a * 4, wd[i], sl[i]);
            chk($sformatf("%s_ack%0d", tag, i), {31'b0, obs_ack}, 32'd1);
            if (wemask[i]) model_write(a, wd[i], sl[i]);
            else           chk($sformatf("%s_dat%0d", tag, i), obs_dat, ref_mem[a]);
        end
        idle();
        chk($sformatf("%s_end", tag), {31'b0, obs_ack}, 32'd0);
    endtask

    initial begin
        cyc = 0; stb = 0; we = 0; cti = 0; bte = 0; adr = 0; wdat = 0; sel = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_dat", rdat, 32'd0);
        chk("err_rty", {30'b0, err, rty}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int w = 0; w < DEPTH / 16; w++)
            do_burst(w * 16, 16, 3'b010, 2'b00, 16'hFFFF, 1'b0, "pre");

        // Classic write/read
        classic(1'b1, 4, 32'hDEADBEEF, 4'hF, 3'b000, "t1_wr");
        classic(1'b0, 4, 32'h0, 4'h0, 3'b000, "t1_rd");
        chk("t1_const", obs_dat, 32'hDEADBEEF);

        // Byte lanes
        classic(1'b1, 8, 32'h11223344, 4'hF, 3'b000, "t2_pre");
        classic(1'b1, 8, 32'hAABBCCDD, 4'h5, 3'b000, "t2_wr");
        step(1, 1, 0, 3'b000, 2'b00, 32'h20, 32'h0, 4'h0);
        step(1, 1, 0, 3'b000, 2'b00, 32'h20, 32'h0, 4'h0);
        chk("t2_merge", obs_dat, 32'h11BB33DD);
        idle();

        // Reserved cti with stb held: classic acks separated by a gap
        step(1, 1, 0, 3'b011, 2'b00, 32'h14, 32'h0, 4'h0);
        chk("rsv_lat", {31'b0, obs_ack}, 32'd0);
        step(1, 1, 0, 3'b011, 2'b00, 32'h14, 32'h0, 4'h0);
        chk("rsv_ack", {31'b0, obs_ack}, 32'd1);
        chk("rsv_dat", obs_dat, ref_mem[5]);
        step(1, 1, 0, 3'b011, 2'b00, 32'h14, 32'h0, 4'h0);
        chk("rsv_gap", {31'b0, obs_ack}, 32'd0);
        idle();

        // Incrementing linear read burst from word 2
        for (int i = 0; i < 8; i++)
            classic(1'b1, i, 32'h01010101 * i, 4'hF, 3'b000, "t3_init");
        do_burst(2, 4, 3'b010, 2'b00, 16'h0000, 1'b0, "t3_rd");
        chk("t3_last", obs_dat, 32'h05050505);

        // 4-beat wrap from word 6, read then write
        do_burst(6, 4, 3'b010, 2'b01, 16'h0000, 1'b0, "t4_rd");
        do_burst(6, 4, 3'b010, 2'b01, 16'hFFFF, 1'b0, "t4_wr");
        for (int i = 4; i < 8; i++)
            classic(1'b0, i, 32'h0, 4'h0, 3'b000, "t4_chk");

        // Constant-address burst mixing writes and reads on one word
        do_burst(9, 5, 3'b001, 2'b00, 16'b01011, 1'b1, "const");

        // Wait state mid-burst, then a new access from word 2
        step(1, 1, 0, 3'b010, 2'b00, 32'h0, 32'h0, 4'h0);
        chk("ws_lat", {31'b0, obs_ack}, 32'd0);
        step(1, 1, 0, 3'b010, 2'b00, 32'h0, 32'h0, 4'h0);
        chk("ws_ack0", {31'b0, obs_ack}, 32'd1);
        chk("ws_dat0", obs_dat, ref_mem[0]);
        step(1, 1, 0, 3'b010, 2'b00, 32'h4, 32'h0, 4'h0);
        chk("ws_ack1", {31'b0, obs_ack}, 32'd1);
        chk("ws_dat1", obs_dat, ref_mem[1]);
        step(1, 0, 0, 3'b010, 2'b00, 32'h8, 32'h0, 4'h0);
        chk("ws_stale", {31'b0, obs_ack}, 32'd1);
        step(1, 1, 0, 3'b111, 2'b00, 32'h8, 32'h0, 4'h0);
        chk("ws_gap", {31'b0, obs_ack}, 32'd0);
        step(1, 1, 0, 3'b111, 2'b00, 32'h8, 32'h0, 4'h0);
        chk("ws_ack2", {31'b0, obs_ack}, 32'd1);
        chk("ws_dat2", obs_dat, ref_mem[2]);
        idle();
        chk("ws_end", {31'b0, obs_ack}, 32'd0);

        // cyc dropped after two write acks: only words 0 and 1 change
        step(1, 1, 1, 3'b010, 2'b00, 32'h0, 32'hA0A0A0A0, 4'hF);
        chk("ab_lat", {31'b0, obs_ack}, 32'd0);
        step(1, 1, 1, 3'b010, 2'b00, 32'h0, 32'hA0A0A0A0, 4'hF);
        chk("ab_ack0", {31'b0, obs_ack}, 32'd1);
        model_write(0, 32'hA0A0A0A0, 4'hF);
        step(1, 1, 1, 3'b010, 2'b00, 32'h4, 32'hA1A1A1A1, 4'hF);
        chk("ab_ack1", {31'b0, obs_ack}, 32'd1);
        model_write(1, 32'hA1A1A1A1, 4'hF);
        step(0, 0, 1, 3'b010, 2'b00, 32'h8, 32'hA2A2A2A2, 4'hF);
        idle();
        chk("ab_drop", {31'b0, obs_ack}, 32'd0);
        for (int i = 0; i < 4; i++)
            classic(1'b0, i, 32'h0, 4'h0, 3'b000, "ab_chk");

        // Asynchronous reset between edges during a read burst
        step(1, 1, 0, 3'b010, 2'b00, 32'h8, 32'h0, 4'h0);
        step(1, 1, 0, 3'b010, 2'b00, 32'h8, 32'h0, 4'h0);
        step(1, 1, 0, 3'b010, 2'b00, 32'hC, 32'h0, 4'h0);
        chk("rb_ack", {31'b0, obs_ack}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rb_ack0", {31'b0, ack}, 32'd0);
        chk("rb_dat0", rdat, 32'd0);
        idle();
        idle();
        rst_n = 1'b1;
        classic(1'b0, 3, 32'h0, 4'h0, 3'b000, "rb_w3");

        // Randomized bursts of every kind
        for (int k = 0; k < 40; k++) begin
            do_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 16)),
                     ($urandom_range(0, 3) == 0) ? 3'b001 : 3'b010,
                     2'($urandom), 16'($urandom), 1'b1, $sformatf("rnd%0d", k));
        end
        do_burst(DEPTH - 2, 4, 3'b010, 2'b00, 16'h0, 1'b0, "lin_wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
